forwarding_hazard_unit: RTL and testbench

Parametrised operand forwarding and load-use hazard unit for the pipelined CPU. It selects, per EX-stage source operand, the youngest later pipeline stage holding a pending write to that register. It also detects load-use hazards between the ID stage and a load in EX, and runs a stall FSM that freezes PC/IF-ID and injects EX bubbles for a configurable load latency. A saturating stall-cycle counter supports performance analysis.

---
 rtl/forwarding_hazard_unit_if.sv | 33 +++
 rtl/forwarding_hazard_unit.sv | 77 +++++++
 tb/tb_forwarding_hazard_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/forwarding_hazard_unit_if.sv
// forwarding_hazard_unit_if: bundles the pipeline-side signals of the forwarding/hazard unit.
//   master: pipeline side; drives register addresses, write enables, valid and flush, and reads back the selects and stall controls
//   slave : hazard unit side; the mirror image of master
interface forwarding_hazard_unit_if #(
   parameter int ADDR_W  = 5,
   parameter int NUM_SRC = 2,
   parameter int NUM_STG = 2,
   parameter int SEL_W   = $clog2(NUM_STG + 1)
);
   logic                       id_valid_i;
   logic [NUM_SRC*ADDR_W-1:0]  id_rs_i;
   logic [NUM_SRC*ADDR_W-1:0]  ex_rs_i;
   logic [ADDR_W-1:0]          ex_rd_i;
   logic                       ex_regwrite_i;
   logic                       ex_memread_i;
   logic [NUM_STG*ADDR_W-1:0]  stg_rd_i;
   logic [NUM_STG-1:0]         stg_regwrite_i;
   logic                       flush_i;
   logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o;
   logic                       stall_o;
   logic                       bubble_o;
   logic [15:0]                stall_cnt_o;
   modport master (
      output id_valid_i, id_rs_i, ex_rs_i, ex_rd_i, ex_regwrite_i, ex_memread_i,
             stg_rd_i, stg_regwrite_i, flush_i,
      input  fwd_sel_o, stall_o, bubble_o, stall_cnt_o
   );
   modport slave (
      input  id_valid_i, id_rs_i, ex_rs_i, ex_rd_i, ex_regwrite_i, ex_memread_i,
             stg_rd_i, stg_regwrite_i, flush_i,
      output fwd_sel_o, stall_o, bubble_o, stall_cnt_o
   );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: EX operand forwarding selects, load-use stall FSM and saturating stall counter.
//   clk_i, rst_i : clock and synchronous active-high reset
//   bus (slave)  : ID/EX register addresses, producer-stage writes and flush in; fwd_sel_o, stall_o, bubble_o
//                  and stall_cnt_o out
module forwarding_hazard_unit #(
   parameter int ADDR_W   = 5,
   parameter int NUM_SRC  = 2,
   parameter int NUM_STG  = 2,
   parameter int LOAD_LAT = 1,
   parameter int SEL_W    = $clog2(NUM_STG + 1)
) (
   input logic clk_i,
   input logic rst_i,
   forwarding_hazard_unit_if.slave bus
);
   typedef enum logic {IDLE, STALL} state_t;
   localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel;
   logic use_hit, hz, stall;
   // Stages are scanned oldest to youngest so the youngest match is written last and wins.
   always_comb begin
      fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++)
         for (int k = NUM_STG - 1; k >= 0; k--)
            if (bus.stg_regwrite_i[k] && bus.stg_rd_i[k*ADDR_W +: ADDR_W] != '0 &&
                bus.stg_rd_i[k*ADDR_W +: ADDR_W] == bus.ex_rs_i[i*ADDR_W +: ADDR_W])
               fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
      if (rst_i) fwd_sel = '0;
   end
   always_comb begin
      use_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
         use_hit = use_hit | (bus.id_rs_i[i*ADDR_W +: ADDR_W] == bus.ex_rd_i);
   end
   assign hz = bus.id_valid_i && !bus.flush_i && bus.ex_memread_i && bus.ex_regwrite_i &&
               bus.ex_rd_i != '0 && use_hit;
   // The first stall cycle is the IDLE cycle in which hz is seen; STALL covers the remaining LOAD_LAT-1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      if (bus.flush_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == STALL) begin
         stall   = 1'b1;
         cnt_d   = cnt_q - 4'd1;
         state_d = (cnt_q == 4'd1) ? IDLE : STALL;
      end else begin
         stall = hz;
         if (hz && LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = LAT_M1;
         end
      end
      if (rst_i) stall = 1'b0;
      stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
   assign bus.fwd_sel_o   = fwd_sel;
   assign bus.stall_o     = stall;
   assign bus.bubble_o    = stall;
   assign bus.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb_forwarding_hazard_unit: three configurations driven by shared stimulus, checked by a queue scoreboard.
module tb_forwarding_hazard_unit;
   typedef struct packed {
      logic [5:0]  fwd;
      logic        stall;
      logic [15:0] cnt;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic       id_valid, ex_regwrite, ex_memread, flush;
   logic [4:0] ex_rd;
   logic [4:0] id_rs [3];
   logic [4:0] ex_rs [3];
   logic [4:0] stg_rd [3];
   logic [2:0] stg_we;
   int   rem  [3];
   int   scnt [3];
   exp_t sb [3][$];
   int   total = 0;
   int   bad   = 0;
   forwarding_hazard_unit_if #(.ADDR_W(5), .NUM_SRC(2), .NUM_STG(2)) b1 ();
   forwarding_hazard_unit_if #(.ADDR_W(5), .NUM_SRC(2), .NUM_STG(2)) b3 ();
   forwarding_hazard_unit_if #(.ADDR_W(5), .NUM_SRC(3), .NUM_STG(3)) b4 ();
   forwarding_hazard_unit #(.LOAD_LAT(1)) d1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave));
   forwarding_hazard_unit #(.LOAD_LAT(3)) d3 (.clk_i(clk), .rst_i(rst), .bus(b3.slave));
   forwarding_hazard_unit #(.NUM_SRC(3), .NUM_STG(3), .LOAD_LAT(4)) d4 (.clk_i(clk), .rst_i(rst), .bus(b4.slave));
   assign b1.id_valid_i = id_valid;  assign b3.id_valid_i = id_valid;  assign b4.id_valid_i = id_valid;
   assign b1.ex_rd_i = ex_rd;        assign b3.ex_rd_i = ex_rd;        assign b4.ex_rd_i = ex_rd;
   assign b1.ex_regwrite_i = ex_regwrite; assign b3.ex_regwrite_i = ex_regwrite; assign b4.ex_regwrite_i = ex_regwrite;
   assign b1.ex_memread_i = ex_memread;   assign b3.ex_memread_i = ex_memread;   assign b4.ex_memread_i = ex_memread;
   assign b1.flush_i = flush;        assign b3.flush_i = flush;        assign b4.flush_i = flush;
   assign b1.id_rs_i = {id_rs[1], id_rs[0]};
   assign b3.id_rs_i = {id_rs[1], id_rs[0]};
   assign b4.id_rs_i = {id_rs[2], id_rs[1], id_rs[0]};
   assign b1.ex_rs_i = {ex_rs[1], ex_rs[0]};
   assign b3.ex_rs_i = {ex_rs[1], ex_rs[0]};
   assign b4.ex_rs_i = {ex_rs[2], ex_rs[1], ex_rs[0]};
   assign b1.stg_rd_i = {stg_rd[1], stg_rd[0]};
   assign b3.stg_rd_i = {stg_rd[1], stg_rd[0]};
   assign b4.stg_rd_i = {stg_rd[2], stg_rd[1], stg_rd[0]};
   assign b1.stg_regwrite_i = stg_we[1:0];
   assign b3.stg_regwrite_i = stg_we[1:0];
   assign b4.stg_regwrite_i = stg_we;
   // Reference: youngest writing stage wins, r0 never forwards; a hazard owes LOAD_LAT stall cycles.
   task automatic model(int d);
      int nsrc, nstg, lat, sel;
      bit hz, st;
      exp_t e;
      nsrc = (d == 2) ? 3 : 2;
      nstg = (d == 2) ? 3 : 2;
      lat  = (d == 0) ? 1 : (d == 1) ? 3 : 4;
      e = '0;
      hz = 1'b0;
      e.cnt = 16'(scnt[d]);
      for (int i = 0; i < nsrc; i++) begin
         sel = 0;
         for (int k = 0; k < nstg; k++)
            if (stg_we[k] && stg_rd[k] != 0 && stg_rd[k] == ex_rs[i]) begin
               sel = k + 1;
               break;
            end
         if (!rst) e.fwd[i*2 +: 2] = 2'(sel);
         if (id_rs[i] == ex_rd) hz = 1'b1;
      end
      hz = hz && id_valid && !flush && ex_memread && ex_regwrite && ex_rd != 0;
      if (rst) begin
         st = 1'b0; rem[d] = 0; scnt[d] = 0;
      end else if (flush) begin
         st = 1'b0; rem[d] = 0;
      end else if (rem[d] > 0) begin
         st = 1'b1; rem[d]--;
      end else begin
         st = hz;
         if (hz) rem[d] = lat - 1;
      end
      if (st && scnt[d] < 65535) scnt[d]++;
      e.stall = st;
      sb[d].push_back(e);
   endtask
   task automatic cmp(int d, string nm, logic [15:0] act, logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL dut%0d %s actual=%h required=%h at %0t", d, nm, act, req, $time);
      end
   endtask
   task automatic chk(int d, logic [5:0] fwd, logic st, logic bu, logic [15:0] cnt);
      exp_t e;
      if (sb[d].size() == 0) return;
      e = sb[d].pop_front();
      cmp(d, "fwd_sel", 16'(fwd), 16'(e.fwd));
      cmp(d, "stall", 16'(st), 16'(e.stall));
      cmp(d, "bubble", 16'(bu), 16'(e.stall));
      cmp(d, "stall_cnt", cnt, e.cnt);
   endtask
   always @(negedge clk) begin
      chk(0, {2'b00, b1.fwd_sel_o}, b1.stall_o, b1.bubble_o, b1.stall_cnt_o);
      chk(1, {2'b00, b3.fwd_sel_o}, b3.stall_o, b3.bubble_o, b3.stall_cnt_o);
      chk(2, b4.fwd_sel_o, b4.stall_o, b4.bubble_o, b4.stall_cnt_o);
   end
   task automatic apply();
      for (int d = 0; d < 3; d++) model(d);
      @(posedge clk);
      #1;
   endtask
   task automatic clear();
      id_valid = 1'b0; ex_regwrite = 1'b0; ex_memread = 1'b0; flush = 1'b0; ex_rd = '0; stg_we = '0;
      for (int i = 0; i < 3; i++) begin
         id_rs[i] = '0; ex_rs[i] = '0; stg_rd[i] = '0;
      end
   endtask
   task automatic load_use();
      id_valid = 1'b1; id_rs[0] = 5'd3; ex_rd = 5'd3; ex_memread = 1'b1; ex_regwrite = 1'b1;
   endtask
   task automatic ex_bubble();
      ex_rd = '0; ex_memread = 1'b0; ex_regwrite = 1'b0;
   endtask
   initial begin
      clear();
      for (int d = 0; d < 3; d++) begin
         rem[d] = 0; scnt[d] = 0;
      end
      @(posedge clk);
      #1;
      apply();
      apply();
      rst = 1'b0;
      ex_rs[0] = 5'd5; stg_rd[0] = 5'd5; stg_rd[1] = 5'd5; stg_we = 3'b011;
      apply();
      stg_we[0] = 1'b0;
      apply();
      ex_rs[0] = '0; stg_rd[0] = '0; stg_rd[1] = '0; stg_rd[2] = '0; stg_we = 3'b111;
      apply();
      clear();
      ex_rs[2] = 5'd9; ex_rs[0] = 5'd4; ex_rs[1] = 5'd6; stg_rd[2] = 5'd9; stg_rd[0] = 5'd7;
      stg_rd[1] = 5'd8; stg_we = 3'b111;
      apply();
      clear();
      load_use();
      apply();
      ex_bubble();
      for (int n = 0; n < 5; n++) apply();
      load_use();
      apply();
      flush = 1'b1;
      apply();
      clear();
      apply();
      apply();
      load_use();
      apply();
      rst = 1'b1;
      apply();
      rst = 1'b0;
      apply();
      clear();
      load_use();
      apply();
      load_use();
      apply();
      ex_bubble();
      for (int n = 0; n < 4; n++) apply();
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         flush = ($urandom_range(0, 9) == 0);
         id_valid = ($urandom_range(0, 3) != 0);
         ex_memread = 1'($urandom_range(0, 1));
         ex_regwrite = ($urandom_range(0, 3) != 0);
         ex_rd = 5'($urandom_range(0, 3));
         stg_we = 3'($urandom_range(0, 7));
         for (int i = 0; i < 3; i++) begin
            id_rs[i] = 5'($urandom_range(0, 3));
            ex_rs[i] = 5'($urandom_range(0, 3));
            stg_rd[i] = 5'($urandom_range(0, 3));
         end
         apply();
      end
      rst = 1'b0;
      clear();
      apply();
      load_use();
      for (int n = 0; n < 65540; n++) apply();
      clear();
      apply();
      apply();
      @(negedge clk);
      #1;
      for (int d = 0; d < 3; d++) cmp(d, "drain", 16'(sb[d].size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
